// File: rtl/note_lane_engine.sv
// note_lane_engine: tracks falling notes in five fret lanes, moves them once
// per frame, resolves strums into hits/misses, and produces registered
// per-pixel sprite flags for the color mapper.
module note_lane_engine #(
  parameter int SLOTS      = 4,
  parameter int SPEED      = 4,
  parameter int SPRITE_W   = 64,
  parameter int SPRITE_H   = 64,
  parameter int LANE_X0    = 160,
  parameter int LANE_PITCH = 64,
  parameter int HIT_Y_MIN  = 384,
  parameter int HIT_Y_MAX  = 416,
  parameter int SCREEN_H   = 480
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       spawn_valid,
  input  logic [2:0] spawn_lane,
  output logic       spawn_ready,
  input  logic [4:0] hit_strobe,
  output logic       is_sprite_red,
  output logic       is_sprite_blue,
  output logic       is_sprite_green,
  output logic       is_sprite_yellow,
  output logic       is_sprite_orange,
  output logic [4:0] hit_pulse,
  output logic [4:0] miss_pulse,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int LANES = 5;

  // All position arithmetic is done in 11 bits so Y + SPEED never wraps.
  localparam logic [10:0] SPEED11    = 11'(SPEED);
  localparam logic [10:0] SPRITE_W11 = 11'(SPRITE_W);
  localparam logic [10:0] SPRITE_H11 = 11'(SPRITE_H);
  localparam logic [10:0] HIT_MIN11  = 11'(HIT_Y_MIN);
  localparam logic [10:0] HIT_MAX11  = 11'(HIT_Y_MAX);
  localparam logic [10:0] SCREEN_H11 = 11'(SCREEN_H);

  // Slot state
  logic [SLOTS-1:0] slot_valid [LANES];
  logic [9:0]       slot_y     [LANES][SLOTS];
  logic [SLOTS-1:0] valid_nxt  [LANES];
  logic [9:0]       y_nxt      [LANES][SLOTS];

  logic             frame_dly;
  logic             tick;
  logic [LANES-1:0] lane_free;
  logic [7:0]       lane_free_ext;
  logic [SLOTS-1:0] hit_sel    [LANES];
  logic [LANES-1:0] hit_evt;
  logic [LANES-1:0] miss_evt;
  logic [3:0]       hit_sum;
  logic [7:0]       miss_sum;
  logic [LANES-1:0] sprite_hit;
  logic [16:0]      hit_acc;
  logic [16:0]      miss_acc;

  assign tick = frame_clk & ~frame_dly;

  // A lane can accept a spawn while any of its slots is free; lanes 5..7 never can.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_free[l] = ~&slot_valid[l];
    end
    lane_free_ext = {3'b000, lane_free};
    spawn_ready   = lane_free_ext[spawn_lane];
  end

  // Per lane, pick the in-window note with the largest pre-move Y (lowest index on ties).
  always_comb begin : hit_select
    logic       found;
    logic [9:0] best_y;
    for (int l = 0; l < LANES; l++) begin
      // NOTE: every combinational output gets a default before any conditional
      // assignment, so no path leaves it holding its old value (no latch).
      hit_sel[l] = '0;
      found      = 1'b0;
      best_y     = '0;
      for (int s = 0; s < SLOTS; s++) begin
        if (slot_valid[l][s] &&
            ({1'b0, slot_y[l][s]} >= HIT_MIN11) &&
            ({1'b0, slot_y[l][s]} <= HIT_MAX11) &&
            (!found || (slot_y[l][s] > best_y))) begin
          hit_sel[l]    = '0;
          hit_sel[l][s] = 1'b1;
          found         = 1'b1;
          best_y        = slot_y[l][s];
        end
      end
    end
  end

  // Next slot state: hits first, then moves/expiry of survivors, then the spawn.
  always_comb begin : next_state
    logic [10:0] sum;
    logic        placed;
    // NOTE: combinational blocks use blocking '=' so later statements see the
    // updated values within the same evaluation; clocked blocks use '<='.
    valid_nxt = slot_valid;
    y_nxt     = slot_y;
    hit_evt   = '0;
    miss_evt  = '0;
    hit_sum   = '0;
    miss_sum  = '0;
    sum       = '0;
    for (int l = 0; l < LANES; l++) begin
      if (hit_strobe[l]) begin
        if (|hit_sel[l]) begin
          hit_evt[l] = 1'b1;
          hit_sum    = hit_sum + 4'd1;
        end else begin
          miss_evt[l] = 1'b1;
          miss_sum    = miss_sum + 8'd1;
        end
      end
      for (int s = 0; s < SLOTS; s++) begin
        if (slot_valid[l][s]) begin
          if (hit_strobe[l] && hit_sel[l][s]) begin
            valid_nxt[l][s] = 1'b0;
          end else if (tick) begin
            sum = {1'b0, slot_y[l][s]} + SPEED11;
            if (sum >= SCREEN_H11) begin
              valid_nxt[l][s] = 1'b0;
              miss_evt[l]     = 1'b1;
              miss_sum        = miss_sum + 8'd1;
            end else begin
              y_nxt[l][s] = sum[9:0];
            end
          end
        end
      end
      // Spawn into the lowest-index slot that is free before this edge.
      placed = 1'b0;
      if (spawn_valid && spawn_ready && (spawn_lane == 3'(l))) begin
        for (int s = 0; s < SLOTS; s++) begin
          if (!slot_valid[l][s] && !placed) begin
            valid_nxt[l][s] = 1'b1;
            y_nxt[l][s]     = '0;
            placed          = 1'b1;
          end
        end
      end
    end
  end

  // Pixel lookup against the slot state present before the clock edge.
  always_comb begin : sprite_lookup
    logic [10:0] lane_x;
    logic        x_in;
    for (int l = 0; l < LANES; l++) begin
      lane_x        = 11'(LANE_X0 + l * LANE_PITCH);
      x_in          = ({1'b0, DrawX} >= lane_x) && ({1'b0, DrawX} < lane_x + SPRITE_W11);
      sprite_hit[l] = 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
        if (slot_valid[l][s] && x_in &&
            ({1'b0, DrawY} >= {1'b0, slot_y[l][s]}) &&
            ({1'b0, DrawY} < {1'b0, slot_y[l][s]} + SPRITE_H11)) begin
          sprite_hit[l] = 1'b1;
        end
      end
    end
  end

  assign hit_acc  = {1'b0, hit_count} + 17'(hit_sum);
  assign miss_acc = {1'b0, miss_count} + 17'(miss_sum);

  // Register slot state, frame edge detector, pulses, counters and sprite flags.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: the slot arrays are small live state, not RAM, so they are reset
      // explicitly; a reset must discard every note in flight.
      for (int l = 0; l < LANES; l++) begin
        slot_valid[l] <= '0;
        for (int s = 0; s < SLOTS; s++) begin
          slot_y[l][s] <= '0;
        end
      end
      frame_dly        <= 1'b1;
      hit_pulse        <= '0;
      miss_pulse       <= '0;
      hit_count        <= '0;
      miss_count       <= '0;
      is_sprite_red    <= 1'b0;
      is_sprite_blue   <= 1'b0;
      is_sprite_green  <= 1'b0;
      is_sprite_yellow <= 1'b0;
      is_sprite_orange <= 1'b0;
    end else begin
      slot_valid       <= valid_nxt;
      slot_y           <= y_nxt;
      frame_dly        <= frame_clk;
      hit_pulse        <= hit_evt;
      miss_pulse       <= miss_evt;
      hit_count        <= hit_acc[16]  ? 16'hFFFF : hit_acc[15:0];
      miss_count       <= miss_acc[16] ? 16'hFFFF : miss_acc[15:0];
      is_sprite_red    <= sprite_hit[0];
      is_sprite_blue   <= sprite_hit[1];
      is_sprite_green  <= sprite_hit[2];
      is_sprite_yellow <= sprite_hit[3];
      is_sprite_orange <= sprite_hit[4];
    end
  end

endmodule

// File: doc/note_lane_engine.md
Name: note_lane_engine

Overview:
- Upstream feeder of the color mapper: owns every falling note in the five fret lanes (red, blue, green, yellow, orange).
- Each lane has a small pool of note slots. Notes are spawned by the chart sequencer, advance once per video frame, and retire on a player strum hit or on falling off-screen.
- Per pixel, produces the registered is_sprite_* flags that the color mapper consumes, plus hit/miss pulses and score counters.

Parameters:
- SLOTS, 4: note slots per lane (1..8).
- SPEED, 4: pixels a note advances per frame tick.
- SPRITE_W, 64: note sprite width in pixels.
- SPRITE_H, 64: note sprite height in pixels.
- LANE_X0, 160: left X of lane 0 (red).
- LANE_PITCH, 64: X spacing between lanes; must be >= SPRITE_W.
- HIT_Y_MIN, 384: lowest note-top Y that counts as a hit (inclusive).
- HIT_Y_MAX, 416: highest note-top Y that counts as a hit (inclusive).
- SCREEN_H, 480: visible height in lines.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- frame_clk  in  1  VGA vertical sync, same clock domain; its rising edge is the frame tick.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- spawn_valid  in  1  spawn request.
- spawn_lane  in  3  lane of the spawn request: 0=red, 1=blue, 2=green, 3=yellow, 4=orange.
- spawn_ready  out  1  a spawn is accepted this cycle.
- hit_strobe  in  5  one-cycle strum per lane; bit i = lane i.
- is_sprite_red  out  1  registered pixel-in-note flag, lane 0.
- is_sprite_blue  out  1  registered pixel-in-note flag, lane 1.
- is_sprite_green  out  1  registered pixel-in-note flag, lane 2.
- is_sprite_yellow  out  1  registered pixel-in-note flag, lane 3.
- is_sprite_orange  out  1  registered pixel-in-note flag, lane 4.
- hit_pulse  out  5  per-lane one-cycle hit indication.
- miss_pulse  out  5  per-lane one-cycle miss indication.
- hit_count  out  16  saturating hit total.
- miss_count  out  16  saturating miss total.

Behaviour:
- Slot state: valid bit plus 10-bit Y (top edge of the note). Lane i left X = LANE_X0 + i*LANE_PITCH.
- Reset (async, Reset_n=0):
  - all slots invalid, all Y = 0;
  - all is_sprite_* = 0; hit_pulse = 0; miss_pulse = 0; hit_count = 0; miss_count = 0;
  - frame_clk delay register = 1, so no spurious tick on release.
  - Reset mid-flight discards all notes immediately.
- Frame tick: frame_clk=1 while its delay register=0; one cycle per frame.
- Move (on tick): each valid slot Y <= Y + SPEED.
  - Sum computed in 11 bits, so there is no wrap.
  - If sum >= SCREEN_H: slot goes invalid (expiry) and counts as a miss event for that lane.
- Spawn handshake:
  - spawn_ready is combinational: high when spawn_lane <= 4 and that lane has at least one free slot. Lanes 5..7 keep it low.
  - Transfer occurs when spawn_valid && spawn_ready. The lowest-index free slot becomes valid with Y = 0.
  - A request held while not ready is neither lost nor counted; the requester retries.
- Hit (hit_strobe[i]=1):
  - Candidates: valid slots in lane i with HIT_Y_MIN <= Y <= HIT_Y_MAX, using the pre-move Y.
  - The candidate with the largest Y is removed; ties go to the lowest index. Lane i takes a hit event.
  - No candidate means a miss event for lane i (bad strum).
- Same-cycle ordering:
  - Hit evaluation sees Y before any move in that cycle.
  - A slot removed by a hit is not moved and does not expire.
  - A slot spawned this cycle is not moved until the next tick, and cannot be hit this cycle.
- Pulses: registered, asserted the cycle after the event, one cycle wide.
  - hit_pulse[i] = lane i had a hit event.
  - miss_pulse[i] = lane i had one or more miss events.
- Counters: registered.
  - hit_count adds the number of hit events in the cycle (0..5).
  - miss_count adds all miss events: expiries plus bad strums, up to 5*SLOTS+5.
  - Both saturate at 16'hFFFF.
- Sprite flags:
  - is_sprite_<lane> is registered with exactly 1-cycle latency after DrawX/DrawY, which matches the color mapper's synchronous frame-RAM read.
  - Flag is 1 if any valid slot in that lane satisfies laneX <= DrawX < laneX+SPRITE_W and Y <= DrawY < Y+SPRITE_H. Comparisons are 11-bit.
  - Lanes never overlap, so at most one flag is set.
- Slot state updates and sprite lookups may coincide; the lookup uses the slot state present before the clock edge.

Test Plan:
- Reset, spawn lane 0, then 96 frame ticks (Y=384). Drive DrawX=160, DrawY=384 -> is_sprite_red=1 the next cycle. Drive DrawX=224 -> all flags 0. Drive DrawY=448 -> is_sprite_red=0.
- From the same state, hit_strobe=5'b00001 -> next cycle hit_pulse=5'b00001, hit_count=1; is_sprite_red=0 thereafter.
- Spawn lane 4, then 120 ticks -> on tick 120 (Y would be 480) the slot frees; next cycle miss_pulse=5'b10000, miss_count=1.
- Spawn lane 2 four times -> spawn_ready=1 each time. Fifth request -> spawn_ready=0, no state change. Request with spawn_lane=6 -> spawn_ready=0.
- Lane 1 slots at Y=388 and Y=400, hit_strobe[1] on the same cycle as a frame tick -> Y=400 slot removed; Y=388 slot becomes 392. Strum with no note in window -> miss_count +1.
- Spawn three lanes, 50 ticks, assert Reset_n=0 mid-frame -> all outputs 0 immediately. After release, no flags until a new spawn, and no tick on the first cycle even with frame_clk=1.
